// File: rtl/rvv_backend_pkg.sv
// rvv_backend_pkg: shared uop payload type and default geometry for the RVV uop queue.
package rvv_backend_pkg;

    localparam int NUM_DE_INST_DEFAULT = 2;
    localparam int NUM_DE_UOP_DEFAULT  = 4;
    localparam int NUM_DP_UOP_DEFAULT  = 2;
    localparam int UQ_DEPTH_DEFAULT    = 16;

    typedef struct packed {
        logic [15:0] id;
        logic [2:0]  uop_index;
        logic        last_uop;
        logic [4:0]  vd;
    } UOP_QUEUE_t;

endpackage

// File: rtl/rvv_uop_compact_queue_if.sv
// rvv_uop_compact_queue_if: decode-side push and dispatch-side pop signals of the uop queue.
interface rvv_uop_compact_queue_if
    import rvv_backend_pkg::*;
#(
    parameter int NUM_DE_INST = NUM_DE_INST_DEFAULT,
    parameter int NUM_DE_UOP  = NUM_DE_UOP_DEFAULT,
    parameter int NUM_DP_UOP  = NUM_DP_UOP_DEFAULT
) ();

    logic       [NUM_DE_INST-1:0][NUM_DE_UOP-1:0] uop_valid_de2uq;
    UOP_QUEUE_t [NUM_DE_INST-1:0][NUM_DE_UOP-1:0] uop_de2uq;
    logic       [NUM_DE_INST-1:0]                 uop_ready_uq2de;
    logic       [NUM_DP_UOP-1:0]                  uop_valid_uq2dp;
    UOP_QUEUE_t [NUM_DP_UOP-1:0]                  uop_uq2dp;
    logic       [NUM_DP_UOP-1:0]                  uop_ready_dp2uq;
    logic                                         trap_flush_rvv;

    modport master (
        output uop_valid_de2uq, uop_de2uq, uop_ready_dp2uq, trap_flush_rvv,
        input  uop_ready_uq2de, uop_valid_uq2dp, uop_uq2dp
    );

    modport slave (
        input  uop_valid_de2uq, uop_de2uq, uop_ready_dp2uq, trap_flush_rvv,
        output uop_ready_uq2de, uop_valid_uq2dp, uop_uq2dp
    );

endinterface

// File: rtl/rvv_uop_compactor.sv
// rvv_uop_compactor: packs valid uops of all instructions into program order with per-inst counts and prefix sums.
module rvv_uop_compactor
    import rvv_backend_pkg::*;
#(
    parameter int NUM_INST = NUM_DE_INST_DEFAULT,
    parameter int NUM_UOP  = NUM_DE_UOP_DEFAULT,
    localparam int CW = $clog2(NUM_UOP + 1),
    localparam int SW = $clog2(NUM_INST * NUM_UOP + 1),
    localparam int PW = (NUM_INST * NUM_UOP > 1) ? $clog2(NUM_INST * NUM_UOP) : 1
) (
    input  logic       [NUM_INST-1:0][NUM_UOP-1:0] valid,
    input  UOP_QUEUE_t [NUM_INST-1:0][NUM_UOP-1:0] payload,
    output logic       [NUM_INST-1:0][CW-1:0]      cnt,
    output logic       [NUM_INST-1:0][SW-1:0]      prefix,
    output UOP_QUEUE_t [NUM_INST*NUM_UOP-1:0]      packed_uop,
    output logic       [SW-1:0]                    total
);

    always_comb begin
        logic [PW-1:0] pos;
        logic [SW-1:0] run;
        pos        = '0;
        run        = '0;
        cnt        = '0;
        prefix     = '0;
        packed_uop = '0;
        for (int i = 0; i < NUM_INST; i++) begin
            for (int l = 0; l < NUM_UOP; l++) begin
                if (valid[i][l]) begin
                    packed_uop[pos] = payload[i][l];
                    pos             = pos + PW'(1);
                    cnt[i]          = cnt[i] + CW'(1);
                end
            end
            run       = run + SW'(cnt[i]);
            prefix[i] = run;
        end
    end

    assign total = prefix[NUM_INST-1];

endmodule

// File: rtl/rvv_uop_compact_queue.sv
// rvv_uop_compact_queue: multi-push/multi-pop compacted uop FIFO between RVV decode and dispatch.
// Optional UOP_QUEUE_BYPASS_EN: an empty queue forwards fired uops to dispatch in the same cycle.
module rvv_uop_compact_queue
    import rvv_backend_pkg::*;
#(
    parameter int NUM_DE_INST = NUM_DE_INST_DEFAULT,
    parameter int NUM_DE_UOP  = NUM_DE_UOP_DEFAULT,
    parameter int NUM_DP_UOP  = NUM_DP_UOP_DEFAULT,
    parameter int DEPTH       = UQ_DEPTH_DEFAULT
) (
    input logic                      clk,
    input logic                      rst_n,
    rvv_uop_compact_queue_if.slave   uq
);

    localparam int NT  = NUM_DE_INST * NUM_DE_UOP;
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int NCW = $clog2(NUM_DE_UOP + 1);
    localparam int SW  = $clog2(NT + 1);
    localparam int PW  = (NT > 1) ? $clog2(NT) : 1;
    localparam int PPW = $clog2(NUM_DP_UOP + 1);

    UOP_QUEUE_t storage [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, free;

    logic       [NUM_DE_INST-1:0][NCW-1:0] cnt;
    logic       [NUM_DE_INST-1:0][SW-1:0]  prefix;
    UOP_QUEUE_t [NT-1:0]                   packed_uop;
    logic [SW-1:0]  total, push_n, stored_n;
    logic [PPW-1:0] pop_n, pop_store, skip;
    logic           byp;

    rvv_uop_compactor #(
        .NUM_INST (NUM_DE_INST),
        .NUM_UOP  (NUM_DE_UOP)
    ) u_compactor (
        .valid      (uq.uop_valid_de2uq),
        .payload    (uq.uop_de2uq),
        .cnt        (cnt),
        .prefix     (prefix),
        .packed_uop (packed_uop),
        .total      (total)
    );

    assign free = CW'(DEPTH) - count;

    // Readiness chains through instructions; absent ones add 0 so never break the chain.
    always_comb begin
        logic ok;
        ok                 = !uq.trap_flush_rvv;
        push_n             = '0;
        uq.uop_ready_uq2de = '0;
        for (int i = 0; i < NUM_DE_INST; i++) begin
            ok                    = ok && (free >= CW'(prefix[i]));
            uq.uop_ready_uq2de[i] = ok;
            if (ok && cnt[i] != '0) push_n = prefix[i];
        end
    end

`ifdef UOP_QUEUE_BYPASS_EN
    assign byp = (count == '0) && !uq.trap_flush_rvv;
    always_comb begin
        uq.uop_valid_uq2dp = '0;
        uq.uop_uq2dp       = '0;
        for (int k = 0; k < NUM_DP_UOP; k++) begin
            uq.uop_valid_uq2dp[k] = byp ? (SW'(k) < push_n) : (count > CW'(k));
            uq.uop_uq2dp[k]       = byp ? packed_uop[k] : storage[rptr + AW'(k)];
        end
    end
`else
    assign byp = 1'b0;
    always_comb begin
        uq.uop_valid_uq2dp = '0;
        uq.uop_uq2dp       = '0;
        for (int k = 0; k < NUM_DP_UOP; k++) begin
            uq.uop_valid_uq2dp[k] = count > CW'(k);
            uq.uop_uq2dp[k]       = storage[rptr + AW'(k)];
        end
    end
`endif

    always_comb begin
        logic go;
        go    = 1'b1;
        pop_n = '0;
        for (int k = 0; k < NUM_DP_UOP; k++) begin
            go    = go && uq.uop_valid_uq2dp[k] && uq.uop_ready_dp2uq[k];
            pop_n = pop_n + PPW'(go);
        end
    end

    // Bypassed uops consumed this cycle never touch storage or the pointers.
    assign skip      = byp ? pop_n : '0;
    assign pop_store = byp ? '0 : pop_n;
    assign stored_n  = push_n - SW'(skip);

    always_ff @(posedge clk) begin
        for (int j = 0; j < NT; j++) begin
            if (SW'(j) < stored_n) storage[wptr + AW'(j)] <= packed_uop[PW'(j) + PW'(skip)];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || uq.trap_flush_rvv) begin
            count <= '0;
            wptr  <= '0;
            rptr  <= '0;
        end else begin
            wptr  <= wptr + AW'(stored_n);
            rptr  <= rptr + AW'(pop_store);
            count <= count + CW'(stored_n) - CW'(pop_store);
        end
    end

endmodule

// File: tb/tb_rvv_uop_compact_queue.sv
// tb_rvv_uop_compact_queue: directed checks of push/pop, full, wrap, flush and optional bypass.
module tb_rvv_uop_compact_queue;
    import rvv_backend_pkg::*;

    localparam int NI = NUM_DE_INST_DEFAULT;
    localparam int NU = NUM_DE_UOP_DEFAULT;
    localparam int ND = NUM_DP_UOP_DEFAULT;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rvv_uop_compact_queue_if #(.NUM_DE_INST(NI), .NUM_DE_UOP(NU), .NUM_DP_UOP(ND)) uq ();

    rvv_uop_compact_queue #(
        .NUM_DE_INST (NI),
        .NUM_DE_UOP  (NU),
        .NUM_DP_UOP  (ND),
        .DEPTH       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .uq    (uq.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_inst(input int i, input int n, input logic [15:0] base);
        for (int l = 0; l < NU; l++) begin
            uq.uop_valid_de2uq[i][l] = (l < n);
            uq.uop_de2uq[i][l]       = '0;
            uq.uop_de2uq[i][l].id    = base + 16'(l);
        end
    endtask

    task automatic idle_de();
        for (int i = 0; i < NI; i++) set_inst(i, 0, 16'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        uq.trap_flush_rvv  = 1'b0;
        uq.uop_ready_dp2uq = '0;
        idle_de();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_count", 32'(dut.count), 0);
        check("rst_valid", 32'(uq.uop_valid_uq2dp), 0);
        set_inst(0, 4, 16'h1);
        set_inst(1, 4, 16'h5);
        #1;
        check("rst_ready_full_pattern", 32'(uq.uop_ready_uq2de), 2'b11);

        // Three uops, drained two then one
        idle_de();
        set_inst(0, 3, 16'hA0);
        uq.uop_ready_dp2uq = 2'b11;
        tick();
        idle_de();
        #1;
        check("t1_count", 32'(dut.count), 3);
        check("t1_valid", 32'(uq.uop_valid_uq2dp), 2'b11);
        check("t1_lane0", 32'(uq.uop_uq2dp[0].id), 16'hA0);
        check("t1_lane1", 32'(uq.uop_uq2dp[1].id), 16'hA1);
        tick();
        check("t1_valid_c", 32'(uq.uop_valid_uq2dp), 2'b01);
        check("t1_lane0_c", 32'(uq.uop_uq2dp[0].id), 16'hA2);
        tick();
        check("t1_count_end", 32'(dut.count), 0);
        check("t1_valid_end", 32'(uq.uop_valid_uq2dp), 0);

        // Fill to 14 then partial accept
        uq.uop_ready_dp2uq = 2'b00;
        set_inst(0, 4, 16'h10);
        set_inst(1, 4, 16'h14);
        tick();
        check("fill_count8", 32'(dut.count), 8);
        set_inst(0, 4, 16'h18);
        set_inst(1, 2, 16'h1C);
        tick();
        check("fill_count14", 32'(dut.count), 14);
        set_inst(0, 2, 16'h20);
        set_inst(1, 1, 16'h22);
        #1;
        check("near_full_ready", 32'(uq.uop_ready_uq2de), 2'b01);
        tick();
        check("full_count", 32'(dut.count), 16);
        check("full_ready", 32'(uq.uop_ready_uq2de), 2'b00);

        // Full with dispatch popping: no pop credit
        set_inst(0, 1, 16'h30);
        set_inst(1, 0, 16'h0);
        uq.uop_ready_dp2uq = 2'b11;
        #1;
        check("full_pop_ready", 32'(uq.uop_ready_uq2de), 2'b00);
        tick();
        idle_de();
        #1;
        check("full_pop_count", 32'(dut.count), 14);
        check("full_pop_lane0", 32'(uq.uop_uq2dp[0].id), 16'h12);
        check("full_pop_lane1", 32'(uq.uop_uq2dp[1].id), 16'h13);

        // Non-prefix dispatch ready pops nothing
        tick();
        tick();
        check("drain_count10", 32'(dut.count), 10);
        uq.uop_ready_dp2uq = 2'b10;
        tick();
        check("nonprefix_count", 32'(dut.count), 10);
        check("nonprefix_lane0", 32'(uq.uop_uq2dp[0].id), 16'h16);
        uq.uop_ready_dp2uq = 2'b01;
        tick();
        check("pop1_count", 32'(dut.count), 9);
        check("pop1_lane0", 32'(uq.uop_uq2dp[0].id), 16'h17);

        // Flush with push and pop active
        set_inst(0, 2, 16'h60);
        uq.uop_ready_dp2uq = 2'b11;
        uq.trap_flush_rvv  = 1'b1;
        #1;
        check("flush_ready", 32'(uq.uop_ready_uq2de), 2'b00);
        tick();
        uq.trap_flush_rvv = 1'b0;
        idle_de();
        #1;
        check("flush_count", 32'(dut.count), 0);
        check("flush_wptr", 32'(dut.wptr), 0);
        check("flush_rptr", 32'(dut.rptr), 0);
        check("flush_valid", 32'(uq.uop_valid_uq2dp), 0);

        // Move pointers to 14 then push across the wrap
        uq.uop_ready_dp2uq = 2'b00;
        set_inst(0, 4, 16'h70);
        set_inst(1, 4, 16'h74);
        tick();
        set_inst(0, 4, 16'h78);
        set_inst(1, 2, 16'h7C);
        uq.uop_ready_dp2uq = 2'b11;
        tick();
        check("pushpop_count", 32'(dut.count), 12);
        idle_de();
        repeat (6) tick();
        check("wrap_pre_rptr", 32'(dut.rptr), 14);
        check("wrap_pre_wptr", 32'(dut.wptr), 14);
        check("wrap_pre_count", 32'(dut.count), 0);
        uq.uop_ready_dp2uq = 2'b00;
        set_inst(0, 4, 16'h40);
        tick();
        idle_de();
        #1;
        check("wrap_wptr", 32'(dut.wptr), 2);
        check("wrap_lane0_a", 32'(uq.uop_uq2dp[0].id), 16'h40);
        check("wrap_lane1_a", 32'(uq.uop_uq2dp[1].id), 16'h41);
        uq.uop_ready_dp2uq = 2'b11;
        tick();
        check("wrap_lane0_b", 32'(uq.uop_uq2dp[0].id), 16'h42);
        check("wrap_lane1_b", 32'(uq.uop_uq2dp[1].id), 16'h43);
        check("wrap_rptr_mid", 32'(dut.rptr), 0);
        tick();
        check("wrap_count_end", 32'(dut.count), 0);
        check("wrap_rptr_end", 32'(dut.rptr), 2);

`ifdef UOP_QUEUE_BYPASS_EN
        set_inst(0, 3, 16'h50);
        uq.uop_ready_dp2uq = 2'b11;
        #1;
        check("byp_valid", 32'(uq.uop_valid_uq2dp), 2'b11);
        check("byp_lane0", 32'(uq.uop_uq2dp[0].id), 16'h50);
        check("byp_lane1", 32'(uq.uop_uq2dp[1].id), 16'h51);
        tick();
        idle_de();
        uq.uop_ready_dp2uq = 2'b00;
        #1;
        check("byp_count", 32'(dut.count), 1);
        check("byp_wptr", 32'(dut.wptr), 3);
        check("byp_lane0_stored", 32'(uq.uop_uq2dp[0].id), 16'h52);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
